// File: rtl/lns_align_stage.sv
// Operand-alignment front end for the LNS fused multiply-add: selects the larger-magnitude
// operand and forms the saturated Gaussian-log table index, as a two-stage valid/ready pipeline.
module lns_align_stage #(
  parameter int LW        = 11,
  parameter int ADD_SHIFT = 2,
  parameter int SUB_SHIFT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [LW-1:0] a_log,
  input  logic [LW-1:0] b_log,
  input  logic          a_sign,
  input  logic          b_sign,
  input  logic          a_zero,
  input  logic          b_zero,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] out_max_log,
  output logic          out_sign,
  output logic          out_sub,
  output logic [5:0]    out_idx,
  output logic          out_bypass,
  output logic          out_zero
);

  localparam logic [LW:0] ADD_SAT = (LW+1)'(31);
  localparam logic [LW:0] SUB_SAT = (LW+1)'(63);

  // Stage 1: raw operands plus the sign-extended log difference
  logic          s1_valid;
  logic [LW-1:0] s1_a_log, s1_b_log;
  logic          s1_a_sign, s1_b_sign, s1_a_zero, s1_b_zero;
  logic [LW:0]   s1_d;

  logic s1_adv, s2_adv;
  logic [LW:0] d_next;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // One extra bit makes the difference of two LW-bit signed values exact.
  assign d_next = {a_log[LW-1], a_log} - {b_log[LW-1], b_log};

  // NOTE: data registers are reset as well so every output is a defined 0 after reset;
  // they are plain flops, not memories, so the reset costs nothing structural.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a_log  <= '0;
      s1_b_log  <= '0;
      s1_a_sign <= 1'b0;
      s1_b_sign <= 1'b0;
      s1_a_zero <= 1'b0;
      s1_b_zero <= 1'b0;
      s1_d      <= '0;
    end else if (s1_adv) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a_log  <= a_log;
        s1_b_log  <= b_log;
        s1_a_sign <= a_sign;
        s1_b_sign <= b_sign;
        s1_a_zero <= a_zero;
        s1_b_zero <= b_zero;
        s1_d      <= d_next;
      end
    end
  end

  // Stage 2 combinational alignment
  logic          d_neg;
  logic [LW:0]   mag, add_sh, sub_sh;
  logic [5:0]    add_idx, sub_idx;
  logic [LW-1:0] nxt_max_log;
  logic          nxt_sign, nxt_sub, nxt_bypass, nxt_zero;
  logic [5:0]    nxt_idx;

  assign d_neg   = s1_d[LW];
  assign mag     = d_neg ? -s1_d : s1_d;
  assign add_sh  = mag >> ADD_SHIFT;
  assign sub_sh  = mag >> SUB_SHIFT;
  // Saturate on the full-width value so large differences never alias to small indices.
  assign add_idx = (add_sh > ADD_SAT) ? 6'd31 : add_sh[5:0];
  assign sub_idx = (sub_sh > SUB_SAT) ? 6'd63 : sub_sh[5:0];

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    nxt_max_log = '0;
    nxt_sign    = 1'b0;
    nxt_sub     = 1'b0;
    nxt_idx     = '0;
    nxt_bypass  = 1'b0;
    nxt_zero    = 1'b0;
    if (s1_a_zero && s1_b_zero) begin
      nxt_zero = 1'b1;
    end else if (s1_a_zero) begin
      nxt_bypass  = 1'b1;
      nxt_max_log = s1_b_log;
      nxt_sign    = s1_b_sign;
    end else if (s1_b_zero) begin
      nxt_bypass  = 1'b1;
      nxt_max_log = s1_a_log;
      nxt_sign    = s1_a_sign;
    end else begin
      nxt_max_log = d_neg ? s1_b_log  : s1_a_log;
      nxt_sign    = d_neg ? s1_b_sign : s1_a_sign;
      nxt_sub     = s1_a_sign ^ s1_b_sign;
      nxt_idx     = nxt_sub ? sub_idx : add_idx;
      nxt_zero    = nxt_sub && (mag == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_max_log <= '0;
      out_sign    <= 1'b0;
      out_sub     <= 1'b0;
      out_idx     <= '0;
      out_bypass  <= 1'b0;
      out_zero    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_max_log <= nxt_max_log;
        out_sign    <= nxt_sign;
        out_sub     <= nxt_sub;
        out_idx     <= nxt_idx;
        out_bypass  <= nxt_bypass;
        out_zero    <= nxt_zero;
      end
    end
  end

endmodule

// File: tb/tb_lns_align_stage.sv
// Self-checking bench for lns_align_stage: directed literal cases, backpressure, reset,
// and randomized traffic against an arithmetic reference model with an in-order scoreboard.
module tb_lns_align_stage;

  localparam int LW = 11;

  typedef struct packed {
    logic [LW-1:0] max_log;
    logic          sign;
    logic          sub;
    logic [5:0]    idx;
    logic          bypass;
    logic          zero;
  } res_t;

  typedef struct {
    res_t r;
    bit   bz;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LW-1:0] a_log = '0, b_log = '0;
  logic          a_sign = 1'b0, b_sign = 1'b0, a_zero = 1'b0, b_zero = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [LW-1:0] out_max_log;
  logic          out_sign, out_sub, out_bypass, out_zero;
  logic [5:0]    out_idx;

  res_t dut_res;
  assign dut_res = {out_max_log, out_sign, out_sub, out_idx, out_bypass, out_zero};

  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;
  exp_t sb[$];

  lns_align_stage #(.LW(LW), .ADD_SHIFT(2), .SUB_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_log(a_log), .b_log(b_log), .a_sign(a_sign), .b_sign(b_sign),
    .a_zero(a_zero), .b_zero(b_zero), .out_valid(out_valid), .out_ready(out_ready),
    .out_max_log(out_max_log), .out_sign(out_sign), .out_sub(out_sub),
    .out_idx(out_idx), .out_bypass(out_bypass), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t mk(input int mx, input bit s, input bit sb_, input int idx,
                              input bit byp, input bit z);
    res_t r;
    r.max_log = LW'(mx);
    r.sign    = s;
    r.sub     = sb_;
    r.idx     = 6'(idx);
    r.bypass  = byp;
    r.zero    = z;
    return r;
  endfunction

  // Reference: plain integer arithmetic on the signed log values.
  function automatic res_t model(input logic [LW-1:0] al, input bit as, input bit az,
                                 input logic [LW-1:0] bl, input bit bs, input bit bz);
    int a, b, mag, idx;
    bit sub;
    a = $signed(al);
    b = $signed(bl);
    if (az && bz) return mk(0, 0, 0, 0, 0, 1);
    if (az)       return mk(b, bs, 0, 0, 1, 0);
    if (bz)       return mk(a, as, 0, 0, 1, 0);
    mag = (a >= b) ? a - b : b - a;
    sub = (as != bs);
    if (sub) idx = (mag > 63) ? 63 : mag;
    else     idx = (mag / 4 > 31) ? 31 : mag / 4;
    return mk((a >= b) ? a : b, (a >= b) ? as : bs, sub, idx, 0, sub && mag == 0);
  endfunction

  // Both-zero results leave sub/idx unconstrained, so they are not compared there.
  function automatic res_t mask(input res_t r, input bit bz);
    res_t m = r;
    if (bz) begin
      m.sub = 1'b0;
      m.idx = '0;
    end
    return m;
  endfunction

  task automatic drive(input logic [LW-1:0] al, input bit as, input bit az,
                       input logic [LW-1:0] bl, input bit bs, input bit bz);
    a_log = al; a_sign = as; a_zero = az;
    b_log = bl; b_sign = bs; b_zero = bz;
  endtask

  // Scoreboard / compare process, sampling on the falling edge.
  initial begin
    bit   prev_stalled = 0;
    res_t prev_res = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stalled = 0;
      end else begin
        if (prev_stalled) begin
          check("stall_hold_valid", 32'(out_valid), 32'd1);
          check("stall_hold_data", 32'(dut_res), 32'(prev_res));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 32'd0, 32'd1);
          end else begin
            e = sb.pop_front();
            check("out_vs_model", 32'(mask(dut_res, e.bz)), 32'(mask(e.r, e.bz)));
            n_out++;
          end
        end
        prev_stalled = out_valid && !out_ready;
        prev_res     = dut_res;
        if (in_valid && in_ready) begin
          e.r  = model(a_log, a_sign, a_zero, b_log, b_sign, b_zero);
          e.bz = a_zero && b_zero;
          sb.push_back(e);
        end
      end
    end
  end

  // Single pair with no backpressure: literal expectation, model pin, and latency.
  task automatic send_and_check(input string name,
                                input logic [LW-1:0] al, input bit as, input bit az,
                                input logic [LW-1:0] bl, input bit bs, input bit bz,
                                input res_t exp);
    int lat;
    bit got;
    bit both;
    both = az && bz;
    check({name, "_model"}, 32'(mask(model(al, as, az, bl, bs, bz), both)), 32'(mask(exp, both)));
    @(posedge clk); #1;
    drive(al, as, az, bl, bs, bz);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
    else begin
      check({name, "_latency"}, 32'(lat), 32'd2);
      check({name, "_dut"}, 32'(mask(dut_res, both)), 32'(mask(exp, both)));
    end
  endtask

  initial begin
    logic [LW-1:0] bp_a[4], bp_b[4];
    bit            bp_as[4], bp_bs[4];
    int k, n0, hs, cyc, mode;
    bit saw_low;

    // Reset state
    #12;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_outputs", 32'(dut_res), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;

    send_and_check("add_basic",  LW'(100), 0, 0, LW'(40),  0, 0, mk(100, 0, 0, 15, 0, 0));
    send_and_check("sub_sat",    LW'(-200), 0, 0, LW'(300), 1, 0, mk(300, 1, 1, 63, 0, 0));
    send_and_check("add_sat",    LW'(-200), 0, 0, LW'(300), 0, 0, mk(300, 0, 0, 31, 0, 0));
    send_and_check("cancel",     LW'(77), 0, 0, LW'(77),  1, 0, mk(77, 0, 1, 0, 0, 1));
    send_and_check("a_zero",     LW'(999), 0, 1, LW'(5),  1, 0, mk(5, 1, 0, 0, 1, 0));
    send_and_check("b_zero",     LW'(-7), 1, 0, LW'(444), 0, 1, mk(-7, 1, 0, 0, 1, 0));
    send_and_check("both_zero",  LW'(321), 1, 1, LW'(-9), 1, 1, mk(0, 0, 0, 0, 0, 1));
    send_and_check("tie_same",   LW'(5), 1, 0, LW'(5),   1, 0, mk(5, 1, 0, 0, 0, 0));
    send_and_check("sub_edge63", LW'(0), 0, 0, LW'(-63), 1, 0, mk(0, 0, 1, 63, 0, 0));
    send_and_check("sub_edge64", LW'(-64), 1, 0, LW'(0), 0, 0, mk(0, 0, 1, 63, 0, 0));
    send_and_check("add_edge123", LW'(10), 0, 0, LW'(-113), 0, 0, mk(10, 0, 0, 30, 0, 0));
    send_and_check("add_edge124", LW'(-114), 1, 0, LW'(10), 1, 0, mk(10, 1, 0, 31, 0, 0));
    send_and_check("extreme",    LW'(-1024), 0, 0, LW'(1023), 1, 0, mk(1023, 1, 1, 63, 0, 0));

    // Backpressure: 4 back-to-back pairs, out_ready low for cycles 2..6
    bp_a = '{LW'(12), LW'(-50), LW'(300), LW'(8)};
    bp_b = '{LW'(3),  LW'(20),  LW'(-300), LW'(8)};
    bp_as = '{0, 1, 0, 1};
    bp_bs = '{0, 0, 1, 0};
    k = 0;
    n0 = n_out;
    saw_low = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 2 && c <= 6);
      if (k < 4) begin
        in_valid = 1'b1;
        drive(bp_a[k], bp_as[k], 0, bp_b[k], bp_bs[k], 0);
      end else in_valid = 1'b0;
      @(negedge clk);
      if (!in_ready) saw_low = 1;
      if (in_valid && in_ready) k++;
    end
    check("bp_in_ready_dropped", 32'(saw_low), 32'd1);
    check("bp_all_accepted", 32'(k), 32'd4);
    check("bp_all_emitted", 32'(n_out - n0), 32'd4);

    // Reset with both stages full
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(LW'(40), 0, 0, LW'(1), 0, 0);
    @(posedge clk); #1;
    drive(LW'(-3), 1, 0, LW'(90), 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_reset_full", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_out_valid", 32'(out_valid), 32'd0);
    check("async_reset_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(posedge clk); #3;
    rst = 1'b0;
    out_ready = 1'b1;
    saw_low = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) saw_low = 1;
    end
    check("no_stale_after_reset", 32'(saw_low), 32'd0);
    send_and_check("post_reset", LW'(64), 1, 0, LW'(0), 1, 0, mk(64, 1, 0, 16, 0, 0));

    // Random traffic with random backpressure
    hs = 0;
    cyc = 0;
    while (hs < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      a_log  = LW'($urandom);
      mode   = $urandom_range(0, 7);
      case (mode)
        0:       b_log = a_log;
        1:       b_log = a_log + LW'($urandom_range(0, 130));
        2:       b_log = a_log - LW'($urandom_range(0, 130));
        default: b_log = LW'($urandom);
      endcase
      a_sign    = 1'($urandom);
      b_sign    = 1'($urandom);
      a_zero    = ($urandom_range(0, 9) == 0);
      b_zero    = ($urandom_range(0, 9) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (in_valid && in_ready) hs++;
      cyc++;
    end
    check("random_handshakes", 32'(hs), 32'd10000);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      if (sb.size() == 0) break;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lns_align_stage.md
# lns_align_stage

Operand-alignment front end of the LNS fused multiply-add datapath. It accepts the product term and the addend in sign/log form and picks the larger-magnitude operand. It computes the magnitude of the log difference and turns it into the saturated table index used by the Gaussian-log add/subtract tables downstream. It is a two-stage valid/ready pipeline that sits directly upstream of the table lookup and final log-sum adder.

## Interface
- LW, 11: width of signed log field (two's complement, fixed point)
- ADD_SHIFT, 2: right shift applied to |d| to form the add-path index
- SUB_SHIFT, 0: right shift applied to |d| to form the subtract-path index
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  stage can accept operand pair
- a_log, b_log  input  LW  signed log magnitudes (a = product, b = addend)
- a_sign, b_sign  input  1  value signs (1 = negative)
- a_zero, b_zero  input  1  operand is exact zero (log field ignored)
- out_valid  output  1  aligned result valid
- out_ready  input  1  downstream accepts result
- out_max_log  output  LW  log of larger-magnitude operand
- out_sign  output  1  sign of larger-magnitude operand (result sign)
- out_sub  output  1  effective subtraction (signs differ)
- out_idx  output  6  table index; add path uses [4:0], [5] = 0
- out_bypass  output  1  exactly one operand zero: result = out_max_log/out_sign, skip table
- out_zero  output  1  both operands zero, or exact cancellation

## Operation
- Transfer at input when in_valid && in_ready; at output when out_valid && out_ready.
- Stage 1 registers the raw operands and computes d = a_log − b_log, sign-extended to LW+1 bits (no overflow possible).
- Stage 2 registers the aligned result:
  - d ≥ 0: max = a, mag = d.
  - d < 0: max = b, mag = −d.
  - Tie (d = 0): a is taken as max.
- out_sub = a_sign ^ b_sign.
- Index:
  - Add path: idx = min(mag >> ADD_SHIFT, 31).
  - Subtract path: idx = min(mag >> SUB_SHIFT, 63).
  - Saturation is a compare on the full LW+1-bit shifted value, not truncation.
- Zero handling:
  - Exactly one zero: out_bypass = 1; max/sign are taken from the nonzero operand; idx = 0, out_sub = 0.
  - Both zero: out_zero = 1, out_bypass = 0, sign = 0, max_log = 0.
- Exact cancellation (out_sub = 1, mag = 0, no zero flags): out_zero = 1; idx = 0 is still emitted.
- Flags are mutually exclusive: at most one of out_bypass / out_zero is set.

## Timing
- Latency: 2 cycles from input handshake to out_valid with no stall. Throughput is one pair per cycle.
- Pipeline control:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready; no skid buffer.
- Stalled stages hold all data registers stable. out_* must not change while out_valid && !out_ready.
- Bubbles collapse: an empty stage 2 accepts from stage 1 regardless of out_ready.
- Reset:
  - Asynchronous assertion clears s1_valid, s2_valid and every output register to 0, so out_valid = 0 and in_ready = 1 after reset.
  - Reset mid-operation discards in-flight pairs with no partial output.
- Simultaneous input and output handshakes in one cycle with both stages full: the pipeline shifts, and nothing is lost or duplicated.

## Test plan
- Add path, LW = 11: a = (+, 100), b = (+, 40) → after 2 cycles, max_log = 100, sign = 0, sub = 0, idx = 15.
- Subtract and negative d: a = (+, −200), b = (−, 300) → max_log = 300, sign = 1, sub = 1, idx = 63 (saturated); same pair with equal signs → idx = 31.
- Cancellation and zeros:
  - a = (+, 77), b = (−, 77) → out_zero = 1, idx = 0.
  - a_zero = 1, b = (−, 5) → bypass = 1, max_log = 5, sign = 1.
  - Both zero → out_zero = 1.
- Backpressure: 4 back-to-back pairs with out_ready low for cycles 2–6 → in_ready drops after 2 are held. All 4 outputs emerge in order, unchanged while stalled, none dropped.
- Reset: assert rst with both stages full → out_valid = 0 immediately (asynchronous). After release, no stale result appears; a new pair completes in 2 cycles.
- Random: 10k random pairs with random out_ready, checked against a reference model for max/sign/sub/idx/flags and ordering.
